wb_mem_tester: RTL and testbench
================================

Name: wb_mem_tester

Overview:
- Wishbone B4 classic initiator that exercises a Wishbone memory responder, such as the DDR3 bridge.
- Runs a write pass over a configurable word range, then a read-back pass, and compares every read word against the expected pattern.
- Reports pass/fail, error count and first failing location for board bring-up of the DDR3 path.

Parameters:
- ADDR_BASE, 32'h0000_0000: byte address of the first tested word; must be 4-byte aligned.
- NUM_WORDS, 256: number of 32-bit words tested; legal range 1..65536.
- TIMEOUT_CYCLES, 1024: maximum cycles a single transaction may wait for ack/err; legal range 1..65535.

Ports:
- clk_i, input, 1: single clock; all logic is on its rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- start_i, input, 1: level-sampled start request, accepted only in IDLE.
- seed_i, input, 32: pattern seed, captured when start is accepted.
- invert_i, input, 1: pattern polarity select, captured when start is accepted.
- wb_cyc_o, output, 1: Wishbone cycle.
- wb_stb_o, output, 1: Wishbone strobe.
- wb_we_o, output, 1: Wishbone write enable.
- wb_adr_o, output, 32: Wishbone byte address.
- wb_dat_o, output, 32: Wishbone write data.
- wb_sel_o, output, 4: Wishbone byte selects; constant 4'hF while a cycle is active, else 0.
- wb_ack_i, input, 1: Wishbone acknowledge.
- wb_err_i, input, 1: Wishbone error.
- wb_dat_i, input, 32: Wishbone read data.
- busy_o, output, 1: high from start acceptance until DONE.
- done_o, output, 1: level; high in DONE until the next accepted start or reset.
- pass_o, output, 1: valid while done_o is high; 1 means no errors and no timeout.
- timeout_o, output, 1: sticky per run; set when a transaction times out.
- err_count_o, output, 16: mismatches plus bus errors; saturates at 16'hFFFF.
- fail_addr_o, output, 32: byte address of the first failure.
- fail_data_o, output, 32: read data of the first failure; 0 if the first failure was a bus error.

Behaviour:
- Reset values: all Wishbone outputs 0; busy_o=0, done_o=0, pass_o=0, timeout_o=0, err_count_o=0, fail_addr_o=0, fail_data_o=0. State=IDLE.
- Reset mid-run: cyc/stb drop at the same edge; no further bus activity.
- Index idx: 17-bit internal counter.
- Address: ADDR_BASE + {idx[15:0],2'b00}, computed mod 2^32.
- Expected pattern: P(idx) = seed ^ {16'h0,idx[15:0]} ^ {idx[15:0],16'h0}, XORed with 32'hFFFF_FFFF when invert is set.
- States and transitions:
  - IDLE: if start_i=1, capture seed/invert, idx=0, clear err_count/fail/timeout, busy=1, done=0, go to WR.
  - WR: cyc=stb=we=1, adr=A(idx), dat=P(idx); outputs held stable until termination. On termination, drop cyc/stb the next cycle and go to WR_GAP.
  - WR_GAP: one cycle with cyc=stb=0. If idx=NUM_WORDS-1, set idx=0 and go to RD; else idx+1 and go to WR.
  - RD: cyc=stb=1, we=0, adr=A(idx). On ack, compare wb_dat_i with P(idx) in the same cycle; on mismatch, count a failure. Then go to RD_GAP.
  - RD_GAP: one idle cycle. If idx=NUM_WORDS-1, go to DONE; else idx+1 and go to RD.
  - DONE: busy=0, done=1, pass=(err_count==0)&~timeout. start_i=1 restarts as in IDLE.
- Termination and error precedence:
  - A transaction terminates on wb_ack_i|wb_err_i while cyc&stb are high.
  - If ack and err are asserted together, err wins: counted as a bus error and no data compare.
  - A bus error counts a failure and the run continues.
- First failure capture: fail_addr_o/fail_data_o are captured only when err_count goes from 0 to 1; later failures do not overwrite them.
- Timeout:
  - A per-transaction wait counter starts at 0 when stb rises.
  - When it reaches TIMEOUT_CYCLES-1 with no termination: drop cyc/stb, set timeout_o, count a failure, go directly to DONE (run aborted).
- Latency: start accepted at edge N; first stb is high after edge N. Each transaction takes (ack latency + 1 gap) cycles.
- Ignored inputs: ack/err outside an active cycle are ignored; start_i while busy is ignored.
- Saturation: err_count stays at 16'hFFFF once reached.

Test Plan:
- Zero-wait responder that acks the cycle after stb, NUM_WORDS=4, seed=0, invert=0 → writes 0x00000000, 0x00010001, 0x00020002, 0x00030003 to addresses 0,4,8,12; reads match; done=1, pass=1, err_count=0.
- Responder returns data XOR 0x1 on the third read (idx=2), NUM_WORDS=4 → err_count=1, fail_addr=0x8, fail_data=0x00020003, pass=0.
- Responder never acks, TIMEOUT_CYCLES=16 → stb drops after 16 cycles on the first write; timeout=1, err_count=1, done=1, pass=0, no further cycles.
- Responder asserts ack and err together on the write at idx=1 → err_count=1, fail_addr=ADDR_BASE+4, fail_data=0; run completes all reads.
- rst_i asserted during RD at idx=2 → cyc/stb=0 next cycle, all outputs at reset values; a subsequent start_i runs a full clean pass with pass=1.
- Responder with 5-cycle ack latency, invert=1, seed=0xA5A5A5A5 → the write at idx=0 carries 0x5A5A5A5A; addr/dat/we held stable for all wait cycles; start_i pulsed while busy has no effect.

Source files
------------

// File: rtl/wb_mem_tester.sv
// Wishbone B4 classic memory tester: writes a seeded pattern over a word range,
// reads it back, and reports pass/fail, error count and first failing location.
module wb_mem_tester #(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int          NUM_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  input  logic        invert_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] fail_addr_o,
  output logic [31:0] fail_data_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // WR     | write transaction active, waiting for ack/err
  // WR_GAP | one idle cycle between writes
  // RD     | read transaction active, compare on ack
  // RD_GAP | one idle cycle between reads
  // DONE   | results valid, start re-arms
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_GAP,
    S_RD,
    S_RD_GAP,
    S_DONE
  } state_e;

  localparam logic [16:0] LAST_IDX = 17'(NUM_WORDS - 1);
  localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] seed_q, seed_d;
  logic        invert_q, invert_d;
  logic [15:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] fail_addr_q, fail_addr_d;
  logic [31:0] fail_data_q, fail_data_d;

  logic [31:0] cur_adr;
  logic [31:0] cur_pat;
  logic        term;
  logic        clear;
  logic        fail_ev;
  logic [31:0] fail_dat;

  assign cur_adr = ADDR_BASE + {14'b0, idx_q[15:0], 2'b00};
  assign cur_pat = seed_q ^ {16'h0, idx_q[15:0]} ^ {idx_q[15:0], 16'h0} ^ {32{invert_q}};
  assign term    = wb_ack_i | wb_err_i;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    invert_d  = invert_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    clear     = 1'b0;
    fail_ev   = 1'b0;
    fail_dat  = 32'h0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = 32'h0;
    wb_dat_o  = 32'h0;
    wb_sel_o  = 4'h0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          seed_d    = seed_i;
          invert_d  = invert_i;
          idx_d     = 17'd0;
          wait_d    = WAIT_LOAD;
          timeout_d = 1'b0;
          clear     = 1'b1;
          state_d   = S_WR;
        end
      end

      S_WR: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = cur_adr;
        wb_dat_o = cur_pat;
        wb_sel_o = 4'hF;
        if (term) begin
          fail_ev = wb_err_i;
          state_d = S_WR_GAP;
        end else if (wait_q == 16'd0) begin
          timeout_d = 1'b1;
          fail_ev   = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end

      S_WR_GAP: begin
        wait_d = WAIT_LOAD;
        if (idx_q == LAST_IDX) begin
          idx_d   = 17'd0;
          state_d = S_RD;
        end else begin
          idx_d   = idx_q + 17'd1;
          state_d = S_WR;
        end
      end

      S_RD: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = cur_adr;
        wb_sel_o = 4'hF;
        if (term) begin
          // err takes precedence over ack: no data compare on a bus error
          if (wb_err_i) begin
            fail_ev = 1'b1;
          end else if (wb_dat_i != cur_pat) begin
            fail_ev  = 1'b1;
            fail_dat = wb_dat_i;
          end
          state_d = S_RD_GAP;
        end else if (wait_q == 16'd0) begin
          timeout_d = 1'b1;
          fail_ev   = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end

      S_RD_GAP: begin
        wait_d = WAIT_LOAD;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 17'd1;
          state_d = S_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (clear) begin
      err_cnt_d   = 16'h0;
      fail_addr_d = 32'h0;
      fail_data_d = 32'h0;
    end else if (fail_ev) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (err_cnt_q == 16'h0) begin
        fail_addr_d = cur_adr;
        fail_data_d = fail_dat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 17'd0;
      seed_q      <= 32'h0;
      invert_q    <= 1'b0;
      wait_q      <= 16'h0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= 16'h0;
      fail_addr_q <= 32'h0;
      fail_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      invert_q    <= invert_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign busy_o      = (state_q == S_WR) || (state_q == S_WR_GAP) ||
                       (state_q == S_RD) || (state_q == S_RD_GAP);
  assign done_o      = (state_q == S_DONE);
  assign pass_o      = done_o && (err_cnt_q == 16'h0) && !timeout_q;
  assign timeout_o   = timeout_q;
  assign err_count_o = err_cnt_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed and randomized runs of wb_mem_tester against a behavioural memory
// responder with configurable latency and fault injection.
module tb_wb_mem_tester;

  localparam int NW = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_i, start_i, invert_i;
  logic [31:0] seed_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i;
  logic [31:0] wb_dat_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_count_o;
  logic [31:0] fail_addr_o, fail_data_o;

  int checks = 0;
  int failures = 0;

  wb_mem_tester #(.ADDR_BASE(32'h0), .NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i), .invert_i(invert_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .err_count_o(err_count_o), .fail_addr_o(fail_addr_o),
    .fail_data_o(fail_data_o)
  );

  always #5 clk = ~clk;

  // responder configuration and observation
  int          lat = 0;
  int          corrupt_idx = -1;
  int          err_idx = -1;
  bit          never_ack = 1'b0;
  int          rcnt = 0;
  int          stb_cycles = 0;
  int          unstable = 0;
  logic [31:0] h_adr, h_dat;
  logic        h_we;
  logic [31:0] mem [16];
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic [31:0] rd_adr_q[$];

  always @(negedge clk) begin
    int widx;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    if (wb_cyc_o && wb_stb_o) begin
      stb_cycles++;
      if (rcnt == 0) begin
        h_adr = wb_adr_o;
        h_dat = wb_dat_o;
        h_we  = wb_we_o;
      end else if (h_adr !== wb_adr_o || h_dat !== wb_dat_o || h_we !== wb_we_o ||
                   wb_sel_o !== 4'hF) begin
        unstable++;
      end
      if (!never_ack && rcnt >= lat) begin
        widx = int'(wb_adr_o[5:2]);
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          mem[widx] = wb_dat_o;
          wr_adr_q.push_back(wb_adr_o);
          wr_dat_q.push_back(wb_dat_o);
          if (widx == err_idx) wb_err_i = 1'b1;
        end else begin
          wb_dat_i = mem[widx] ^ ((widx == corrupt_idx) ? 32'h1 : 32'h0);
          rd_adr_q.push_back(wb_adr_o);
        end
        rcnt = 0;
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
    end
  end

  function automatic logic [31:0] pat_m(input logic [31:0] s, input bit inv, input int i);
    logic [31:0] k;
    logic [31:0] v;
    k = 32'(i % 65536);
    v = s ^ k ^ (k << 16);
    return inv ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"}, {31'b0, wb_cyc_o}, 32'h0);
    check({tag, "_stb"}, {31'b0, wb_stb_o}, 32'h0);
    check({tag, "_we"},  {31'b0, wb_we_o}, 32'h0);
    check({tag, "_adr"}, wb_adr_o, 32'h0);
    check({tag, "_dat"}, wb_dat_o, 32'h0);
    check({tag, "_sel"}, {28'b0, wb_sel_o}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
    check({tag, "_done"}, {31'b0, done_o}, 32'h0);
    check({tag, "_pass"}, {31'b0, pass_o}, 32'h0);
    check({tag, "_tmo"},  {31'b0, timeout_o}, 32'h0);
    check({tag, "_errc"}, {16'b0, err_count_o}, 32'h0);
    check({tag, "_fadr"}, fail_addr_o, 32'h0);
    check({tag, "_fdat"}, fail_data_o, 32'h0);
  endtask

  task automatic start_run(input logic [31:0] s, input bit inv);
    wr_adr_q.delete();
    wr_dat_q.delete();
    rd_adr_q.delete();
    stb_cycles = 0;
    unstable = 0;
    @(negedge clk);
    seed_i   = s;
    invert_i = inv;
    start_i  = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    seed_i   = $urandom;
    invert_i = 1'($urandom);
    check("busy_after_start", {31'b0, busy_o}, 32'h1);
    check("done_after_start", {31'b0, done_o}, 32'h0);
  endtask

  task automatic do_run(input string tag, input logic [31:0] s, input bit inv, input int l,
                        input int c, input int e, input bit nev, input bit pulse_busy);
    int          k;
    int          exp_err;
    logic [31:0] exp_fa, exp_fd;
    lat = l;
    corrupt_idx = c;
    err_idx = e;
    never_ack = nev;
    start_run(s, inv);
    if (pulse_busy) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      check({tag, "_busy_hold"}, {31'b0, busy_o}, 32'h1);
    end
    k = 0;
    while (!done_o && k < 1000) begin
      @(posedge clk);
      #1 k++;
    end
    check({tag, "_done_wait"}, {31'b0, done_o}, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_done_level"}, {31'b0, done_o}, 32'h1);
    check({tag, "_busy_end"}, {31'b0, busy_o}, 32'h0);
    check({tag, "_unstable"}, 32'(unstable), 32'h0);

    if (nev) begin
      check({tag, "_stb_cycles"}, 32'(stb_cycles), 32'(TO));
      check({tag, "_tmo"}, {31'b0, timeout_o}, 32'h1);
      check({tag, "_errc"}, {16'b0, err_count_o}, 32'h1);
      check({tag, "_pass"}, {31'b0, pass_o}, 32'h0);
      check({tag, "_fadr"}, fail_addr_o, 32'h0);
      check({tag, "_fdat"}, fail_data_o, 32'h0);
      check({tag, "_nwr"}, 32'(wr_adr_q.size()), 32'h0);
    end else begin
      exp_err = (e >= 0 ? 1 : 0) + (c >= 0 ? 1 : 0);
      exp_fa = 32'h0;
      exp_fd = 32'h0;
      if (e >= 0) begin
        exp_fa = 32'(e * 4);
      end else if (c >= 0) begin
        exp_fa = 32'(c * 4);
        exp_fd = pat_m(s, inv, c) ^ 32'h1;
      end
      check({tag, "_stb_cycles"}, 32'(stb_cycles), 32'(2 * NW * (l + 1)));
      check({tag, "_nwr"}, 32'(wr_adr_q.size()), 32'(NW));
      check({tag, "_nrd"}, 32'(rd_adr_q.size()), 32'(NW));
      for (int i = 0; i < NW; i++) begin
        if (i < wr_adr_q.size()) begin
          check({tag, "_wr_adr"}, wr_adr_q[i], 32'(i * 4));
          check({tag, "_wr_dat"}, wr_dat_q[i], pat_m(s, inv, i));
        end
        if (i < rd_adr_q.size()) check({tag, "_rd_adr"}, rd_adr_q[i], 32'(i * 4));
      end
      check({tag, "_tmo"}, {31'b0, timeout_o}, 32'h0);
      check({tag, "_errc"}, {16'b0, err_count_o}, 32'(exp_err));
      check({tag, "_pass"}, {31'b0, pass_o}, (exp_err == 0) ? 32'h1 : 32'h0);
      check({tag, "_fadr"}, fail_addr_o, exp_fa);
      check({tag, "_fdat"}, fail_data_o, exp_fd);
    end
  endtask

  initial begin
    int k;
    rst_i = 1'b1;
    start_i = 1'b0;
    seed_i = 32'h0;
    invert_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_i = 1'b0;

    // clean pass, zero-wait responder
    do_run("clean", 32'h0, 1'b0, 0, -1, -1, 1'b0, 1'b0);
    if (wr_dat_q.size() > 3) check("clean_wr3_const", wr_dat_q[3], 32'h0003_0003);

    // corrupted third read
    do_run("mismatch", 32'h0, 1'b0, 0, 2, -1, 1'b0, 1'b0);

    // never-acking responder
    do_run("timeout", 32'h1234_5678, 1'b0, 0, -1, -1, 1'b1, 1'b0);

    // ack+err together on write idx 1
    do_run("buserr", 32'h0BAD_F00D, 1'b0, 0, -1, 1, 1'b0, 1'b0);

    // reset during read at idx 2
    lat = 0; corrupt_idx = -1; err_idx = -1; never_ack = 1'b0;
    start_run(32'hCAFE_0001, 1'b0);
    k = 0;
    while (!(wb_stb_o && !wb_we_o && wb_adr_o == 32'h8) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_rd2", {31'b0, wb_stb_o && !wb_we_o}, 32'h1);
    rst_i = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midrst");
    stb_cycles = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("midrst_quiet", 32'(stb_cycles), 32'h0);
    do_run("after_rst", 32'hCAFE_0002, 1'b0, 0, -1, -1, 1'b0, 1'b0);

    // slow responder, inverted pattern, start pulsed while busy
    do_run("slow", 32'hA5A5_A5A5, 1'b1, 5, -1, -1, 1'b0, 1'b1);
    if (wr_dat_q.size() > 0) check("slow_wr0_const", wr_dat_q[0], 32'h5A5A_5A5A);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      do_run("rand", $urandom, 1'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)) - 1, -1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
